// File: rtl/fxp_div32_pkg.sv
// Shared constants and types for the signed Q20.12 sequential divider.
// Widths, iteration count, state encoding and saturation limits live here.
package fxp_div32_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int FRAC_BITS  = 12;
  localparam int ITER       = DATA_WIDTH + FRAC_BITS;
  localparam int CNT_W      = $clog2(ITER + 1);

  localparam logic [DATA_WIDTH-1:0] FXP_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] FXP_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Saturation thresholds on the unsigned ITER-bit quotient magnitude.
  localparam logic [ITER-1:0] Q_POS_LIMIT = {{FRAC_BITS{1'b0}}, FXP_MAX};
  localparam logic [ITER-1:0] Q_NEG_LIMIT = {{FRAC_BITS{1'b0}}, FXP_MIN};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Two's complement magnitude; the most negative value maps to 2^(DW-1) exactly.
  function automatic logic [DATA_WIDTH-1:0] abs_val(input logic [DATA_WIDTH-1:0] v);
    return v[DATA_WIDTH-1] ? (~v + DATA_WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/fxp_div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract
// the divisor magnitude and keep the difference only when it does not go negative.
module fxp_div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem_in,
  input  logic         din,
  input  logic [W-1:0] divisor,
  output logic [W:0]   rem_out,
  output logic         qbit
);

  logic [W+1:0] shifted;
  logic [W+1:0] trial;

  always_comb begin
    shifted = {rem_in, din};
    trial   = shifted - {2'b00, divisor};
    qbit    = (shifted >= {2'b00, divisor});
    rem_out = (W+1)'(qbit ? trial : shifted);
  end

endmodule

// File: rtl/fxp_div32.sv
// Sequential signed fixed-point divider: out = (a << FRAC_BITS) / b, truncated
// toward zero and saturated, one quotient bit per clock.
module fxp_div32
  import fxp_div32_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic                  dz
);

  // Handshake: start is sampled only while busy=0 (IDLE); busy rises the cycle
  // after the accepted start, and done pulses for one cycle when out/ovf/dz are
  // updated. A new start may be accepted in the done cycle; starts while busy are dropped.

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    sign_r;
  logic                    a_neg_r;
  logic                    div_zero_r;
  logic [DATA_WIDTH-1:0]   absb_r;
  logic [ITER-1:0]         dividend_r;
  logic [DATA_WIDTH:0]     rem_r;
  logic [ITER-1:0]         q_r;

  logic [DATA_WIDTH:0]     rem_nxt;
  logic                    qbit;
  logic [DATA_WIDTH-1:0]   fix_out;
  logic                    fix_ovf;

  fxp_div_step #(
    .W (DATA_WIDTH)
  ) u_step (
    .rem_in  (rem_r),
    .din     (dividend_r[ITER-1]),
    .divisor (absb_r),
    .rem_out (rem_nxt),
    .qbit    (qbit)
  );

  // Sign application and saturation of the finished magnitude.
  always_comb begin
    fix_out = q_r[DATA_WIDTH-1:0];
    fix_ovf = 1'b0;
    if (!sign_r && (q_r > Q_POS_LIMIT)) begin
      fix_out = FXP_MAX;
      fix_ovf = 1'b1;
    end else if (sign_r && (q_r > Q_NEG_LIMIT)) begin
      fix_out = FXP_MIN;
      fix_ovf = 1'b1;
    end else if (sign_r) begin
      fix_out = ~q_r[DATA_WIDTH-1:0] + DATA_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      sign_r     <= 1'b0;
      a_neg_r    <= 1'b0;
      div_zero_r <= 1'b0;
      absb_r     <= '0;
      dividend_r <= '0;
      rem_r      <= '0;
      q_r        <= '0;
      out        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
      dz         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sign_r     <= a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1];
            a_neg_r    <= a[DATA_WIDTH-1];
            absb_r     <= abs_val(b);
            dividend_r <= {abs_val(a), {FRAC_BITS{1'b0}}};
            rem_r      <= '0;
            q_r        <= '0;
            cnt        <= '0;
            busy       <= 1'b1;
            div_zero_r <= (b == '0);
            state      <= (b == '0) ? ST_FIX : ST_DIV;
          end
        end
        ST_DIV: begin
          rem_r      <= rem_nxt;
          dividend_r <= {dividend_r[ITER-2:0], 1'b0};
          q_r        <= {q_r[ITER-2:0], qbit};
          cnt        <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(ITER - 1)) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
          if (div_zero_r) begin
            out <= a_neg_r ? FXP_MIN : FXP_MAX;
            ovf <= 1'b0;
            dz  <= 1'b1;
          end else begin
            out <= fix_out;
            ovf <= fix_ovf;
            dz  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
